sample_fifo_sched: RTL

- Sequences one batch read of the sample FIFO and shares its single pop port among N_REQ tree-evaluation engines.
- Programs the element threshold, resets the read pointer and waits for threshold completion.
- Round-robin grants pops to requesting engines and routes each returned sample to its requester via a latency-matched tag pipeline.
- Sits between the PS-loaded sample FIFO and the tree engine array; started by the top-level controller once per inference batch.

---
 rtl/sample_sched_pkg.sv | 18 +
 rtl/pipeline.sv | 31 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/sample_fifo_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sample_sched_pkg.sv
// rtl/sample_sched_pkg.sv - state encoding and round-robin pointer helper for sample_fifo_sched
package sample_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    WAIT_THSH = 3'd2,
    RUN       = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } sched_state_t;

  // Pointer moves one past the winner so the winner drops to lowest priority.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pipeline.sv
// rtl/pipeline.sv - generic cleared shift pipeline with an any-stage-nonzero flag
module pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             occupied
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[STAGES-1];

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < STAGES; i++) occupied = occupied | (|stage[i]);
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr wins
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);

  localparam logic [PW:0] N_W = (PW+1)'(N_REQ);

  logic [PW:0] cand;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (en && !found && req[cand[PW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[PW-1:0]]    = 1'b1;
        idx                  = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sample_fifo_sched.sv
// rtl/sample_fifo_sched.sv - batch sample-FIFO read sequencer and pop arbiter; abort option via SAMPLE_FIFO_SCHED_ABORT_EN
module sample_fifo_sched
  import sample_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH_BIT = 13,
  parameter int RD_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SAMPLE_FIFO_SCHED_ABORT_EN
  input  logic                 i_abort,
  output logic                 o_aborted,
`endif
  input  logic                 i_start,
  input  logic [DEPTH_BIT-1:0] i_num_samples,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic [N_REQ-1:0]     i_req,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [WIDTH-1:0]     o_data,
  output logic [N_REQ-1:0]     o_data_vld,
  output logic                 o_err,
  output logic                 o_fifo_pop,
  input  logic [WIDTH-1:0]     i_fifo_front,
  input  logic                 i_fifo_vld,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_ptr_rst,
  output logic [DEPTH_BIT-1:0] o_fifo_thsh_val,
  output logic                 o_fifo_thsh_vld,
  input  logic                 i_fifo_thsh_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  sched_state_t     state, state_next;
  logic             abort_req;
  logic             arb_en;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    rr_ptr;
  logic             pop;
  logic [N_REQ-1:0] tag_last;
  logic             tag_busy;
  logic             tag_err;
  logic [CW-1:0]    outstanding;

`ifdef SAMPLE_FIFO_SCHED_ABORT_EN
  assign abort_req = i_abort && (state == WAIT_THSH || state == RUN);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    arb_en     = 1'b0;
    case (state)
      IDLE:      if (i_start) state_next = CLR;
      CLR:       state_next = WAIT_THSH;
      WAIT_THSH: begin
        if (abort_req)             state_next = DRAIN;
        else if (i_fifo_thsh_done) state_next = RUN;
      end
      RUN: begin
        if (abort_req || i_fifo_empty) state_next = DRAIN;
        else                           arb_en     = 1'b1;
      end
      DRAIN:     if (outstanding == '0 && !tag_busy) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign pop        = |gnt;
  assign o_gnt      = gnt;
  assign o_fifo_pop = pop;

  // Grant tags travel alongside the FIFO read latency so each returned word knows its owner.
  pipeline #(.WIDTH(N_REQ), .STAGES(RD_LAT)) u_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (gnt),
    .dout     (tag_last),
    .occupied (tag_busy)
  );

  assign tag_err = (i_fifo_vld && tag_last == '0) || (!i_fifo_vld && tag_last != '0);

  assign o_busy          = (state != IDLE);
  assign o_done          = (state == DONE);
  assign o_fifo_ptr_rst  = (state == CLR);
  assign o_fifo_thsh_vld = (state == CLR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      o_fifo_thsh_val <= '0;
      o_data          <= '0;
      o_data_vld      <= '0;
      o_err           <= 1'b0;
      outstanding     <= '0;
    end else begin
      if (state == IDLE && i_start) o_fifo_thsh_val <= i_num_samples;
      if (pop) rr_ptr <= PW'(rr_next(int'(win_idx), N_REQ));
      if (i_fifo_vld) o_data <= i_fifo_front;
      o_data_vld <= i_fifo_vld ? tag_last : '0;
      if (tag_err) o_err <= 1'b1;
      // A stray valid with nothing outstanding is already flagged; keep the count from wrapping.
      if (pop && !i_fifo_vld)
        outstanding <= outstanding + CW'(1);
      else if (!pop && i_fifo_vld && outstanding != '0)
        outstanding <= outstanding - CW'(1);
    end
  end

`ifdef SAMPLE_FIFO_SCHED_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                        o_aborted <= 1'b0;
    else if (state == IDLE && i_start) o_aborted <= 1'b0;
    else if (abort_req)                o_aborted <= 1'b1;
  end
`endif

endmodule
